// File: rtl/lease_alloc_pkg.sv
// Shared constants and FSM encoding for the lease-cache victim allocator.
// Also holds the LFSR polynomial used by the fallback victim generator.
package lease_alloc_pkg;

    localparam int          N_LINES   = 1024;
    localparam int          IDX_W     = 10;
    // Right-shift Galois mask for x^16 + x^14 + x^13 + x^11 + 1.
    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        OFFER  = 2'd2
    } state_e;

endpackage

// File: rtl/lfsr_galois16.sv
// 16-bit Galois LFSR, free-running from reset release; supplies the victim
// index used when no cache line is free.
module lfsr_galois16
    import lease_alloc_pkg::*;
#(
    parameter logic [15:0] SEED = lease_alloc_pkg::LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;

    // NOTE: clocked state is written with <= so every flop samples the values
    // from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_q <= SEED;
        end else begin
            q_q <= {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_POLY : 16'h0000);
        end
    end

    assign q = q_q;

endmodule

// File: rtl/lease_victim_allocator.sv
// Victim allocator for the lease cache: owns the free/expired line vector,
// offers the encoder's lowest free line (or an LFSR pick) via valid/ack.
module lease_victim_allocator
    import lease_alloc_pkg::*;
#(
    parameter int          N_LINES    = lease_alloc_pkg::N_LINES,
    parameter int          IDX_W      = lease_alloc_pkg::IDX_W,
    parameter bit          RESET_FREE = 1'b1,
    parameter logic [15:0] LFSR_SEED  = lease_alloc_pkg::LFSR_SEED
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_en,
    input  logic [IDX_W-1:0]   set_idx,
    output logic [N_LINES-1:0] free_vec,
    input  logic [IDX_W-1:0]   enc_bin,
    input  logic               enc_vld,
    input  logic               alloc_req,
    output logic               alloc_valid,
    output logic [IDX_W-1:0]   alloc_idx,
    output logic               alloc_from_free,
    input  logic               alloc_ack,
    output logic [IDX_W:0]     free_cnt
);

    localparam logic [IDX_W:0] CNT_RST = RESET_FREE ? (IDX_W+1)'(N_LINES) : '0;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cand_idx_q, cand_idx_d;
    logic               cand_free_q, cand_free_d;
    logic [N_LINES-1:0] free_vec_q, free_vec_d;
    logic [IDX_W:0]     free_cnt_q, free_cnt_d;
    logic [15:0]        lfsr;
    logic               lfsr_unused;
    logic               grant;
    logic               clear_en;
    logic               cnt_inc;
    logic               cnt_dec;

    lfsr_galois16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr)
    );

    assign lfsr_unused = ^lfsr[15:IDX_W];

    // NOTE: every signal written here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        cand_idx_d  = cand_idx_q;
        cand_free_d = cand_free_q;
        grant       = 1'b0;
        case (state_q)
            IDLE: begin
                if (alloc_req) state_d = LOOKUP;
            end
            LOOKUP: begin
                cand_idx_d  = enc_vld ? enc_bin : lfsr[IDX_W-1:0];
                cand_free_d = enc_vld;
                state_d     = OFFER;
            end
            OFFER: begin
                if (alloc_ack) begin
                    grant   = 1'b1;
                    state_d = alloc_req ? LOOKUP : IDLE;
                end else if (!alloc_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A set on the granted line wins, so the clear is suppressed outright.
    always_comb begin
        clear_en   = grant && cand_free_q && !(set_en && (set_idx == cand_idx_q));
        cnt_inc    = set_en && !free_vec_q[set_idx];
        cnt_dec    = clear_en && free_vec_q[cand_idx_q];
        free_vec_d = free_vec_q;
        if (clear_en) free_vec_d[cand_idx_q] = 1'b0;
        if (set_en)   free_vec_d[set_idx]    = 1'b1;
        free_cnt_d = free_cnt_q + {{IDX_W{1'b0}}, cnt_inc} - {{IDX_W{1'b0}}, cnt_dec};
    end

    // NOTE: free_vec is architectural state (not a RAM), so it takes a reset
    // value like any other register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cand_idx_q  <= '0;
            cand_free_q <= 1'b0;
            free_vec_q  <= {N_LINES{RESET_FREE}};
            free_cnt_q  <= CNT_RST;
        end else begin
            state_q     <= state_d;
            cand_idx_q  <= cand_idx_d;
            cand_free_q <= cand_free_d;
            free_vec_q  <= free_vec_d;
            free_cnt_q  <= free_cnt_d;
        end
    end

    assign free_vec        = free_vec_q;
    assign free_cnt        = free_cnt_q;
    assign alloc_valid     = (state_q == OFFER);
    assign alloc_idx       = cand_idx_q;
    assign alloc_from_free = cand_free_q;

endmodule
